// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;
    localparam int MAX_W = 64;
    localparam int CW = $clog2(MAX_W);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
    // Two's-complement magnitude when neg is set; callers truncate to their width.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? ~v + MAX_W'(1) : v;
    endfunction
endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division iteration (shift in a dividend bit, trial subtract).
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign shifted = {rem_i, msb_i};
    assign diff    = shifted - {1'b0, divisor_i};
    // Remainder stays below the divisor, so bit WIDTH of diff is exactly the borrow.
    assign qbit_o  = ~diff[WIDTH];
    assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, q_q, q_d, r_q, r_d;
    logic             nq_q, nq_d, nr_q, nr_d, ovfp_q, ovfp_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_qb;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        ovfp_d  = ovfp_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                if (y == '0) begin
                    state_d = DONE;
                    q_d     = '1;
                    r_d     = x;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = CALC;
                    dvd_d   = WIDTH'(abs_w(MAX_W'(x), is_signed & x[WIDTH-1]));
                    dvs_d   = WIDTH'(abs_w(MAX_W'(y), is_signed & y[WIDTH-1]));
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    nq_d    = is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                    nr_d    = is_signed & x[WIDTH-1];
                    ovfp_d  = is_signed & (x == MIN_V) & (y == '1);
                end
            end
            CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_qb};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
                q_d     = WIDTH'(abs_w(MAX_W'(dvd_q), nq_q));
                r_d     = WIDTH'(abs_w(MAX_W'(rem_q), nr_q));
                ovf_d   = ovfp_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            ovfp_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            ovfp_q  <= ovfp_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
endmodule
